barrel_arbiter: RTL

Shares one 8-bit barrel shift/rotate datapath between `N_REQ` independent requesters. Each requester presents a shift job over a valid/ready handshake. The block picks one job per cycle, computes the shift/rotate through the shared datapath, and registers the result with the winning requester's ID on a single valid/ready output port. It sits between the client engines and the shifter, so that only one shifter instance is needed per cluster.

---
 rtl/barrel_arbiter_if.sv | 39 +++
 rtl/barrel_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/barrel_arbiter_if.sv
// -----------------------------------------------------------------------------
// barrel_arbiter_if
// Bundles the requester-side and result-side handshakes of barrel_arbiter.
//   req_valid [N_REQ]     : requester i has a job
//   req_ready [N_REQ]     : requester i's job is accepted this cycle
//   req_data  [8*N_REQ]   : operand, slice [8i+7:8i] for requester i
//   req_amt   [3*N_REQ]   : shift amount 0..7 per requester
//   req_dir   [N_REQ]     : 0 = left, 1 = right
//   req_rot   [N_REQ]     : 1 = rotate, 0 = logical shift
//   out_valid / out_ready : result handshake
//   out_data  [8]         : shifted/rotated result
//   out_id    [ID_W]      : requester that produced out_data
// Modports: master = requesters + consumer, slave = arbiter.
// -----------------------------------------------------------------------------
interface barrel_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [8*N_REQ-1:0] req_data;
    logic [3*N_REQ-1:0] req_amt;
    logic [N_REQ-1:0]   req_dir;
    logic [N_REQ-1:0]   req_rot;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_data;
    logic [ID_W-1:0]    out_id;

    modport master (
        output req_valid, req_data, req_amt, req_dir, req_rot, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_data, req_amt, req_dir, req_rot, out_ready,
        output req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/barrel_arbiter.sv
// -----------------------------------------------------------------------------
// barrel_arbiter
// Shares one 8-bit barrel shift/rotate datapath between N_REQ requesters.
// One job is granted per cycle and its result is registered, together with
// the winner's index, in a single-entry output register.
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : barrel_arbiter_if.slave (requester jobs in, result out)
// Optional feature macro: BARREL_ARB_RR_EN
//   defined   -> round-robin grant starting at ptr
//   undefined -> fixed priority, lowest asserted index wins
// -----------------------------------------------------------------------------
module barrel_arbiter #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned ID_W = $clog2(N_REQ)
) (
    input logic              clk,
    input logic              rst,
    barrel_arbiter_if.slave  bus
);

    typedef enum logic {StEmpty, StFull} occ_e;

    occ_e            r_state;
    logic [7:0]      r_data;
    logic [ID_W-1:0] r_id;
`ifdef BARREL_ARB_RR_EN
    logic [ID_W-1:0] r_ptr;
`endif

    logic             w_any;
    logic             w_free;
    logic             w_accept;
    logic [N_REQ-1:0] w_gnt;
    logic [ID_W-1:0]  w_gnt_idx;
    logic [7:0]       w_op;
    logic [2:0]       w_amt;
    logic             w_dir;
    logic             w_rot;
    logic [15:0]      w_dbl_l;
    logic [15:0]      w_dbl_r;
    logic [7:0]       w_result;

    // Grant search: from ptr upward with wrap (round-robin) or from 0.
    always_comb begin
        int  idx;
        logic found;
        found     = 1'b0;
        idx       = 0;
        w_gnt_idx = '0;
        w_gnt     = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
`ifdef BARREL_ARB_RR_EN
            idx = int'(r_ptr) + k;
            if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
`else
            idx = k;
`endif
            if (!found && bus.req_valid[idx]) begin
                found     = 1'b1;
                w_gnt_idx = ID_W'(idx);
            end
        end
        if (found) w_gnt[w_gnt_idx] = 1'b1;
    end

    assign w_any    = |bus.req_valid;
    assign w_free   = (r_state == StEmpty) || bus.out_ready;
    // Gating with rst keeps req_ready low throughout reset.
    assign w_accept = w_any && w_free && !rst;

    assign bus.req_ready = w_accept ? w_gnt : '0;

    // Shared datapath operating on the granted job.
    assign w_op  = bus.req_data[8*w_gnt_idx +: 8];
    assign w_amt = bus.req_amt[3*w_gnt_idx +: 3];
    assign w_dir = bus.req_dir[w_gnt_idx];
    assign w_rot = bus.req_rot[w_gnt_idx];

    // Rotates come from a doubled operand: the wrapped-around bits land in
    // the selected byte, and amt = 0 degenerates to a pass-through.
    assign w_dbl_l = {w_op, w_op} << w_amt;
    assign w_dbl_r = {w_op, w_op} >> w_amt;

    always_comb begin
        w_result = w_op;
        unique case ({w_dir, w_rot})
            2'b00:   w_result = w_op << w_amt;
            2'b01:   w_result = w_dbl_l[15:8];
            2'b10:   w_result = w_op >> w_amt;
            2'b11:   w_result = w_dbl_r[7:0];
            default: w_result = w_op;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StEmpty;
            r_data  <= 8'h00;
            r_id    <= '0;
`ifdef BARREL_ARB_RR_EN
            r_ptr   <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_state <= StFull;
                r_data  <= w_result;
                r_id    <= w_gnt_idx;
`ifdef BARREL_ARB_RR_EN
                r_ptr   <= (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
`endif
            end else if (bus.out_ready) begin
                // Drain only: data and id keep their last values.
                r_state <= StEmpty;
            end
        end
    end

    assign bus.out_valid = (r_state == StFull);
    assign bus.out_data  = r_data;
    assign bus.out_id    = r_id;

endmodule
